// File: rtl/mold_pkg.sv
// Shared constants, assembly state encoding and keep-mask helpers for the
// MoldUDP64 -> ITCH message gather stage.
package mold_pkg;

    localparam int MOLD_AXI_DATA_W = 64;
    localparam int MOLD_AXI_KEEP_W = MOLD_AXI_DATA_W / 8;
    localparam int ITCH_TYPE_W     = 8;
    localparam int KEEP_CNT_W      = $clog2(MOLD_AXI_KEEP_W + 1);

    typedef logic [1:0] asm_state_t;

    localparam asm_state_t ST_IDLE    = 2'd0;
    localparam asm_state_t ST_ACC     = 2'd1;
    localparam asm_state_t ST_DONE    = 2'd2;
    localparam asm_state_t ST_DISCARD = 2'd3;

    function automatic logic [KEEP_CNT_W-1:0] popcount_keep(
        input logic [MOLD_AXI_KEEP_W-1:0] keep
    );
        logic [KEEP_CNT_W-1:0] cnt;
        cnt = {KEEP_CNT_W{1'b0}};
        for (int i = 0; i < MOLD_AXI_KEEP_W; i++) begin
            cnt = cnt + KEEP_CNT_W'(keep[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/itch_msg_gather_if.sv
// Beat-stream input and record-output bundle of the ITCH message gather stage.
interface itch_msg_gather_if
    import mold_pkg::*;
#(
    parameter int AXI_DATA_W = MOLD_AXI_DATA_W,
    parameter int AXI_KEEP_W = AXI_DATA_W / 8,
    parameter int MAX_BYTES  = 64,
    parameter int LEN_W      = $clog2(MAX_BYTES + 1)
);

    logic                     mold_msg_v_i;
    logic                     mold_msg_start_i;
    logic [AXI_KEEP_W-1:0]    mold_msg_mask_i;
    logic [AXI_DATA_W-1:0]    mold_msg_data_i;
    logic                     itch_msg_v_o;
    logic                     itch_msg_ready_i;
    logic [LEN_W-1:0]         itch_msg_len_o;
    logic [ITCH_TYPE_W-1:0]   itch_msg_type_o;
    logic [8*MAX_BYTES-1:0]   itch_msg_data_o;
    logic                     drop_o;
    logic [15:0]              drop_cnt_o;

    modport master (
        output mold_msg_v_i, mold_msg_start_i, mold_msg_mask_i, mold_msg_data_i,
        output itch_msg_ready_i,
        input  itch_msg_v_o, itch_msg_len_o, itch_msg_type_o, itch_msg_data_o,
        input  drop_o, drop_cnt_o
    );

    modport slave (
        input  mold_msg_v_i, mold_msg_start_i, mold_msg_mask_i, mold_msg_data_i,
        input  itch_msg_ready_i,
        output itch_msg_v_o, itch_msg_len_o, itch_msg_type_o, itch_msg_data_o,
        output drop_o, drop_cnt_o
    );

endinterface

// File: rtl/itch_msg_gather_chk.sv
// Input-contract checker for the beat stream feeding itch_msg_gather.
module itch_msg_gather_chk #(
    parameter int AXI_KEEP_W = 8,
    parameter int IDLE_FLUSH = 2
) (
    input logic                  clk,
    input logic                  reset,
    input logic                  v,
    input logic                  start,
    input logic [AXI_KEEP_W-1:0] mask
);

    logic       open_r;
    logic [7:0] idle_r;

    // Message framing as seen on the stream: open after a full beat until a partial beat or flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            open_r <= 1'b0;
            idle_r <= 8'd0;
        end else if (v) begin
            open_r <= &mask;
            idle_r <= 8'd0;
        end else if (open_r && (idle_r == 8'(IDLE_FLUSH - 1))) begin
            open_r <= 1'b0;
            idle_r <= 8'd0;
        end else if (open_r) begin
            idle_r <= idle_r + 8'd1;
        end else begin
            idle_r <= 8'd0;
        end
    end

    // Contract on every valid beat.
    always_ff @(posedge clk) begin
        if (!reset && v) begin
            assert ((mask & (mask + AXI_KEEP_W'(1))) == {AXI_KEEP_W{1'b0}})
                else $error("contract: non-contiguous mask %b", mask);
            assert (!start || mask[0])
                else $error("contract: start beat does not begin at byte 0");
            assert (start || open_r)
                else $error("contract: continuation beat without an open message");
        end
    end

endmodule

// File: rtl/itch_msg_gather.sv
// Reassembles MoldUDP64 message beats into one wide zero-filled record and
// presents it on a valid/ready port; messages that cannot be held are dropped.
module itch_msg_gather
    import mold_pkg::*;
#(
    parameter int AXI_DATA_W = MOLD_AXI_DATA_W,
    parameter int AXI_KEEP_W = AXI_DATA_W / 8,
    parameter int MAX_BYTES  = 64,
    parameter int LEN_W      = $clog2(MAX_BYTES + 1),
    parameter int IDLE_FLUSH = 2
) (
    input logic               clk,
    input logic               reset,
    itch_msg_gather_if.slave  bus
);

    localparam int REC_W   = 8 * MAX_BYTES;
    localparam int SUM_W   = LEN_W + 1;
    localparam int FLUSH_W = $clog2(IDLE_FLUSH + 1);

    asm_state_t             state_r, state_s;
    logic [REC_W-1:0]       buf_data_r, buf_data_s;
    logic [LEN_W-1:0]       buf_len_r, buf_len_s;
    logic [FLUSH_W-1:0]     flush_r, flush_s;
    logic                   out_v_r;
    logic [LEN_W-1:0]       out_len_r;
    logic [REC_W-1:0]       out_data_r;
    logic                   drop_r;
    logic [15:0]            drop_cnt_r;

    logic                   beat_s, start_s, full_s, slot_free_s;
    logic [AXI_DATA_W-1:0]  masked_s;
    logic [REC_W-1:0]       beat_rec_s, placed_s;
    logic [KEEP_CNT_W-1:0]  pc_s;
    logic [LEN_W-1:0]       pc_len_s;
    logic [SUM_W-1:0]       sum_s;
    logic                   commit_s, drop_s, new_slot_s, take_start_s;
    logic [REC_W-1:0]       commit_data_s;
    logic [LEN_W-1:0]       commit_len_s;

    // Zero the bytes outside the keep mask so records come out zero-filled.
    always_comb begin
        masked_s = {AXI_DATA_W{1'b0}};
        for (int i = 0; i < AXI_KEEP_W; i++) begin
            masked_s[8*i +: 8] = bus.mold_msg_mask_i[i] ? bus.mold_msg_data_i[8*i +: 8] : 8'h00;
        end
    end

    assign beat_s      = bus.mold_msg_v_i;
    assign start_s     = bus.mold_msg_v_i & bus.mold_msg_start_i;
    assign full_s      = &bus.mold_msg_mask_i;
    assign slot_free_s = ~out_v_r | bus.itch_msg_ready_i;
    assign pc_s        = popcount_keep(bus.mold_msg_mask_i);
    assign pc_len_s    = LEN_W'(pc_s);
    assign sum_s       = SUM_W'(buf_len_r) + SUM_W'(pc_s);
    assign beat_rec_s  = REC_W'(masked_s);
    assign placed_s    = buf_data_r | (beat_rec_s << {buf_len_r, 3'b000});

    // Assembly FSM; only one record waits behind the output register, so a start
    // beat arriving while that record cannot move on displaces it.
    always_comb begin
        state_s       = state_r;
        buf_data_s    = buf_data_r;
        buf_len_s     = buf_len_r;
        flush_s       = flush_r;
        commit_s      = 1'b0;
        commit_data_s = buf_data_r;
        commit_len_s  = buf_len_r;
        drop_s        = 1'b0;
        new_slot_s    = slot_free_s;
        take_start_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_DISCARD: begin
                take_start_s = start_s;
            end
            ST_ACC: begin
                if (start_s) begin
                    commit_s     = slot_free_s;
                    drop_s       = ~slot_free_s;
                    new_slot_s   = 1'b0;
                    take_start_s = 1'b1;
                end else if (beat_s) begin
                    flush_s = FLUSH_W'(0);
                    if (sum_s > SUM_W'(MAX_BYTES)) begin
                        drop_s     = 1'b1;
                        state_s    = ST_DISCARD;
                        buf_data_s = {REC_W{1'b0}};
                        buf_len_s  = {LEN_W{1'b0}};
                    end else if (!full_s) begin
                        buf_data_s    = placed_s;
                        buf_len_s     = sum_s[LEN_W-1:0];
                        commit_s      = slot_free_s;
                        commit_data_s = placed_s;
                        commit_len_s  = sum_s[LEN_W-1:0];
                        state_s       = slot_free_s ? ST_IDLE : ST_DONE;
                    end else begin
                        buf_data_s = placed_s;
                        buf_len_s  = sum_s[LEN_W-1:0];
                    end
                end else if (flush_r == FLUSH_W'(IDLE_FLUSH - 1)) begin
                    flush_s  = FLUSH_W'(0);
                    commit_s = slot_free_s;
                    state_s  = slot_free_s ? ST_IDLE : ST_DONE;
                end else begin
                    flush_s = flush_r + FLUSH_W'(1);
                end
            end
            ST_DONE: begin
                if (slot_free_s) begin
                    commit_s     = 1'b1;
                    state_s      = ST_IDLE;
                    new_slot_s   = 1'b0;
                    take_start_s = start_s;
                end else if (start_s) begin
                    drop_s       = 1'b1;
                    new_slot_s   = 1'b0;
                    take_start_s = 1'b1;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (take_start_s) begin
            buf_data_s = beat_rec_s;
            buf_len_s  = pc_len_s;
            flush_s    = FLUSH_W'(0);
            if (full_s) begin
                state_s = ST_ACC;
            end else if (new_slot_s) begin
                commit_s      = 1'b1;
                commit_data_s = beat_rec_s;
                commit_len_s  = pc_len_s;
                state_s       = ST_IDLE;
            end else begin
                state_s = ST_DONE;
            end
        end else begin
            take_start_s = 1'b0;
        end
    end

    // Assembly state, staging buffer and idle-flush counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            buf_data_r <= {REC_W{1'b0}};
            buf_len_r  <= {LEN_W{1'b0}};
            flush_r    <= FLUSH_W'(0);
        end else begin
            state_r    <= state_s;
            buf_data_r <= buf_data_s;
            buf_len_r  <= buf_len_s;
            flush_r    <= flush_s;
        end
    end

    // Output record register; fields hold while valid waits for ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_v_r    <= 1'b0;
            out_len_r  <= {LEN_W{1'b0}};
            out_data_r <= {REC_W{1'b0}};
        end else if (commit_s) begin
            out_v_r    <= 1'b1;
            out_len_r  <= commit_len_s;
            out_data_r <= commit_data_s;
        end else if (bus.itch_msg_ready_i) begin
            out_v_r <= 1'b0;
        end else begin
            out_v_r <= out_v_r;
        end
    end

    // Drop pulse and saturating drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_r     <= 1'b0;
            drop_cnt_r <= 16'h0000;
        end else begin
            drop_r <= drop_s;
            if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'h0001;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign bus.itch_msg_v_o    = out_v_r;
    assign bus.itch_msg_len_o  = out_len_r;
    assign bus.itch_msg_type_o = out_data_r[ITCH_TYPE_W-1:0];
    assign bus.itch_msg_data_o = out_data_r;
    assign bus.drop_o          = drop_r;
    assign bus.drop_cnt_o      = drop_cnt_r;

endmodule

// File: doc/itch_msg_gather.md
# itch_msg_gather

Downstream stage of the MoldUDP64 parser (`top`).
- Consumes the per-message beat stream on the `mold_msg_*` outputs.
- Reassembles each message into one wide, byte-aligned record of up to MAX_BYTES bytes.
- Presents the record on a valid/ready port to the ITCH decoders.
- The parser has no backpressure, so this block accepts every beat. Messages it cannot hold are dropped and counted.

## Interface
Parameters:
- AXI_DATA_W, 64, input beat width in bits
- AXI_KEEP_W, AXI_DATA_W/8, input mask width
- MAX_BYTES, 64, largest record in bytes; a multiple of AXI_KEEP_W
- LEN_W, $clog2(MAX_BYTES+1), record length width
- IDLE_FLUSH, 2, count of consecutive invalid cycles that closes an open message

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- mold_msg_v_i  in  1  beat valid
- mold_msg_start_i  in  1  first beat of a message
- mold_msg_mask_i  in  AXI_KEEP_W  byte valid
- mold_msg_data_i  in  AXI_DATA_W  beat data; byte i at [8i+7:8i]
- itch_msg_v_o  out  1  record valid
- itch_msg_ready_i  in  1  record accepted when v&ready
- itch_msg_len_o  out  LEN_W  record length in bytes, 1..MAX_BYTES
- itch_msg_type_o  out  8  byte 0 of record (ITCH message type)
- itch_msg_data_o  out  8*MAX_BYTES  record bytes; bytes >= len are zero
- drop_o  out  1  one-cycle pulse per dropped message
- drop_cnt_o  out  16  saturating count of dropped messages

## Operation
- Input contract, checked by assertion:
  - mask is contiguous from bit 0.
  - A non-start beat only follows an open message.
  - First message byte is byte 0 of its start beat.
- Assembly state machine: IDLE, ACC, DONE, DISCARD.
  - IDLE, start beat with mask all-ones: load beat at offset 0, byte count = popcount(mask), go to ACC.
  - IDLE, start beat with partial mask: the message completes on this beat.
  - ACC, beat without start: write bytes at the current offset and add popcount.
    - Partial mask: the message completes.
  - ACC, start beat: the open message completes, and the new beat is processed as from IDLE in the same cycle.
  - ACC, IDLE_FLUSH consecutive invalid cycles: the message completes.
  - Overflow (count would exceed MAX_BYTES): drop the message, go to DISCARD, ignore beats until the next start beat.
- Completion and commit:
  - On completion the record commits to the output register if the slot is free: itch_msg_v_o low, or v&ready this cycle. Otherwise it parks in DONE.
  - DONE commits the first cycle the slot frees.
  - A start beat arriving in DONE while the slot is still busy drops the parked record, and the new beat is taken.
  - A start beat in ACC whose new message also completes in that beat: the old record commits if possible, and the new record goes to DONE.
- Drop accounting:
  - Each drop pulses drop_o for one cycle.
  - drop_cnt_o increments by 1 per drop and saturates at 16'hFFFF.
  - Overflow and displacement are never simultaneous, so at most one drop occurs per cycle.
- Output stability: record fields hold stable while v&!ready. Unused bytes are zero-filled on commit.

## Timing
- Reset: all outputs 0, state IDLE, offsets 0, flush counter 0.
  - Mid-message reset discards the open and parked records silently; drop_cnt_o is not incremented.
- Latency, completing beat sampled at edge t with the slot free: itch_msg_v_o high after edge t.
- Latency, completion by IDLE_FLUSH: v_o high after the IDLE_FLUSH-th invalid edge.
- Throughput: one record per cycle when ready is held high.
- Back-to-back single-beat messages with ready low: the second parks in DONE. A third start beat drops the second.

## Structure
- `mold_pkg` holds:
  - AXI_DATA_W and AXI_KEEP_W defaults.
  - The assembly state enum.
  - A `popcount_keep` function.
  - The ITCH type-byte width constant.
- No sub-module.
  - The byte-placement shifter (beat << 8*offset into the record) stays inline.

## Test plan
- 16-byte message (two full beats AAAA.., BBBB..), then start beat of the next → one record, len 16, type 8'hAA, bytes 8..15 = 8'hBB, v_o one cycle after the second start beat.
- 11-byte message (full beat, then mask 8'h07), ready high → len 11, upper 53 bytes zero, v_o after the partial beat edge.
- 24-byte message followed by 2 idle cycles (IDLE_FLUSH=2) → record len 24 after the second idle edge.
- ready low, three single-beat messages (mask 8'h0F) on consecutive cycles → first held in output, second displaced by third: drop_o pulses once, drop_cnt_o=1; raising ready yields records 1 then 3.
- 9 full beats (72 bytes > 64) → drop_o pulses, no record; the following start beat of a 5-byte message → len 5 record.
- reset asserted in ACC mid-message → all outputs 0 asynchronously, drop_cnt_o stays 0; next message reassembles correctly.
